// File: rtl/seq_divider_u16.sv
// Sequential unsigned restoring divider: retires one quotient bit per clock.
// Results are registered on DONE entry and held until the next DONE entry.
module seq_divider_u16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividend,
  input  logic [WIDTH-1:0] iDivisor,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oQuotient,
  output logic [WIDTH-1:0] oRemainder,
  output logic             oDivByZero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH:0]   trial, diff;
  logic             fit;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             accept, div_zero, last_step;

  assign accept    = (state == IDLE) && iStart;
  assign div_zero  = (iDivisor == '0);
  assign last_step = (cnt == '0);
  assign oBusy     = (state != IDLE);
  assign oDone     = (state == DONE);

  // The partial remainder can reach WIDTH bits, so the shifted trial value needs WIDTH+1.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, dvs};
    fit     = (trial >= {1'b0, dvs});
    rem_nxt = fit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fit};
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iStart) state_nxt = div_zero ? DONE : CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      oQuotient  <= '0;
      oRemainder <= '0;
      oDivByZero <= 1'b0;
    end else begin
      if (accept) begin
        dvs <= iDivisor;
        if (!div_zero) begin
          cnt <= CNT_W'(WIDTH - 1);
          rem <= '0;
          quo <= iDividend;
        end
      end else if (state == CALC) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (!last_step) cnt <= cnt - 1'b1;
      end

      // Result registers only move on DONE entry so callers can read them late.
      if (accept && div_zero) begin
        oQuotient  <= '1;
        oRemainder <= iDividend;
        oDivByZero <= 1'b1;
      end else if (state == CALC && last_step) begin
        oQuotient  <= quo_nxt;
        oRemainder <= rem_nxt;
        oDivByZero <= 1'b0;
      end
    end
  end

endmodule
